// File: rtl/vga_scanout.sv
// 640x480@60 VGA scan-out of a 160x120 3-bit framebuffer, each stored pixel shown as a 4x4 block.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_scanout #(
   parameter int H_VISIBLE   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_VISIBLE   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int SCALE_SHIFT = 2
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic [2:0]  fb_data,
   input  logic        test_pattern,
   output logic [14:0] fb_addr,
   output logic        fb_rd_en,
   output logic        frame_start,
   output logic        vblank,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic [9:0]  VGA_R,
   output logic [9:0]  VGA_G,
   output logic [9:0]  VGA_B
);

   localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic       pix_en;
   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       visible;
   logic       tp_sel;
   logic       vld_p0;
   logic       hs_p0;
   logic       vs_p0;
   logic [2:0] bar_p0;

   // Framebuffer rows are 160 wide: row*160 = (row<<7) + (row<<5).
   function automatic logic [14:0] fb_index(input logic [9:0] h, input logic [9:0] v);
      logic [14:0] hs;
      logic [14:0] vs;
      hs = 15'(h >> SCALE_SHIFT);
      vs = 15'(v >> SCALE_SHIFT);
      return (vs << 7) + (vs << 5) + hs;
   endfunction

   function automatic logic [29:0] pin_rgb(input logic vis, input logic [2:0] c);
      logic [2:0] k;
      k = vis ? c : 3'b000;
      return {{10{k[2]}}, {10{k[1]}}, {10{k[0]}}};
   endfunction

`ifdef VGA_TEST_PATTERN_EN
   assign tp_sel = test_pattern;
`else
   logic unused_test_pattern;
   assign unused_test_pattern = test_pattern;
   assign tp_sel = 1'b0;
`endif

   assign visible     = (hcnt < H_VIS) && (vcnt < V_VIS);
   assign vblank      = (vcnt >= V_VIS);
   assign frame_start = pix_en && (hcnt == 10'd0) && (vcnt == V_VIS);
   assign VGA_SYNC_N  = 1'b0;

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         pix_en <= 1'b0;
         hcnt   <= 10'd0;
         vcnt   <= 10'd0;
      end else begin
         pix_en <= ~pix_en;
         if (pix_en) begin
            if (hcnt == H_LAST) begin
               hcnt <= 10'd0;
               vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
            end else begin
               hcnt <= hcnt + 10'd1;
            end
         end
      end
   end

   // Stage 0: issue the framebuffer read and register sync/blank decisions for this tick.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         VGA_CLK  <= 1'b0;
         fb_rd_en <= 1'b0;
         fb_addr  <= 15'd0;
         vld_p0   <= 1'b0;
         hs_p0    <= 1'b1;
         vs_p0    <= 1'b1;
         bar_p0   <= 3'd0;
      end else begin
         VGA_CLK  <= pix_en;
         fb_rd_en <= pix_en && visible && !tp_sel;
         if (pix_en) begin
            if (visible) begin
               fb_addr <= fb_index(hcnt, vcnt);
            end
            vld_p0 <= visible;
            hs_p0  <= !((hcnt >= HS_START) && (hcnt < HS_END));
            vs_p0  <= !((vcnt >= VS_START) && (vcnt < VS_END));
            bar_p0 <= hcnt[9:7];
         end
      end
   end

   // Stage 1: read data has arrived; drive all pins together so colour lines up with sync.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= 10'd0;
         VGA_G       <= 10'd0;
         VGA_B       <= 10'd0;
      end else if (pix_en) begin
         VGA_HS                <= hs_p0;
         VGA_VS                <= vs_p0;
         VGA_BLANK_N           <= vld_p0;
         {VGA_R, VGA_G, VGA_B} <= pin_rgb(vld_p0, tp_sel ? bar_p0 : fb_data);
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: cycle-exact reference model with a colour scoreboard on the full-size
// instance, and whole-frame event counts on a narrow-line instance to keep the run short.
module tb_vga_scanout;

`ifdef VGA_TEST_PATTERN_EN
   localparam bit TP_BUILT = 1'b1;
`else
   localparam bit TP_BUILT = 1'b0;
`endif

   logic        CLOCK_50 = 1'b0;
   logic        reset_n  = 1'b0;
   logic [2:0]  fb_data  = 3'd0;
   logic        test_pattern = 1'b0;
   logic [14:0] fb_addr;
   logic        fb_rd_en, frame_start, vblank, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
   logic [9:0]  VGA_R, VGA_G, VGA_B;

   logic [2:0]  fb_data_s = 3'd0;
   logic        test_pattern_s = 1'b0;
   logic [14:0] fb_addr_s;
   logic        fb_rd_en_s, frame_start_s, vblank_s, clk_s, hs_s, vs_s, blank_n_s, sync_n_s;
   logic [9:0]  r_s, g_s, b_s;

   int checks   = 0;
   int failures = 0;
   bit mem_mode = 1'b0;
   logic [2:0] exp_q[$];

   always #10 CLOCK_50 = ~CLOCK_50;

   vga_scanout dut (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .fb_data(fb_data), .test_pattern(test_pattern),
      .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .frame_start(frame_start), .vblank(vblank),
      .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
      .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   // 16-tick lines, full vertical timing: one frame is 16800 CLOCK_50 cycles.
   vga_scanout #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(4)) dut_s (
      .CLOCK_50(CLOCK_50), .reset_n(reset_n), .fb_data(fb_data_s), .test_pattern(test_pattern_s),
      .fb_addr(fb_addr_s), .fb_rd_en(fb_rd_en_s), .frame_start(frame_start_s), .vblank(vblank_s),
      .VGA_CLK(clk_s), .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(blank_n_s),
      .VGA_SYNC_N(sync_n_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
   );

   function automatic logic [2:0] mem_f(input logic [14:0] a, input bit mode);
      return mode ? 3'b101 : (a[2:0] ^ a[5:3] ^ a[8:6] ^ a[11:9] ^ a[14:12]);
   endfunction

   always @(posedge CLOCK_50) if (fb_rd_en) fb_data <= mem_f(fb_addr, mem_mode);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state();
      chk("rst_hs", 32'(VGA_HS), 32'd1);
      chk("rst_vs", 32'(VGA_VS), 32'd1);
      chk("rst_blank_n", 32'(VGA_BLANK_N), 32'd0);
      chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      chk("rst_rd_en", 32'(fb_rd_en), 32'd0);
      chk("rst_addr", 32'(fb_addr), 32'd0);
      chk("rst_frame_start", 32'(frame_start), 32'd0);
      chk("rst_vblank", 32'(vblank), 32'd0);
      chk("rst_vga_clk", 32'(VGA_CLK), 32'd0);
      chk("sync_n", 32'(VGA_SYNC_N), 32'd0);
   endtask

   // Reference model: n = CLOCK_50 edges since reset release; even edges are pixel ticks.
   int   n = 0;
   int   last_addr = 0;
   always @(negedge CLOCK_50) begin
      int c, t, h, v, tp, hp, vp, col;
      bit vis, visp, etp;
      if (!reset_n) begin
         n = 0;
         last_addr = 0;
         exp_q.delete();
      end else begin
         n++;
         etp = TP_BUILT && test_pattern;
         c = n / 2;
         h = c % 800;
         v = (c / 800) % 525;
         chk("vga_clk", 32'(VGA_CLK), 32'(n % 2 == 0));
         chk("vblank", 32'(vblank), 32'(v >= 480));
         chk("frame_start", 32'(frame_start), 32'((n % 2 == 1) && h == 0 && v == 480));
         if (n % 2 == 1) begin
            chk("rd_en_offtick", 32'(fb_rd_en), 32'd0);
         end else begin
            t = n / 2 - 1;
            h = t % 800;
            v = (t / 800) % 525;
            vis = (h < 640) && (v < 480);
            if (vis) last_addr = (v / 4) * 160 + h / 4;
            chk("rd_en", 32'(fb_rd_en), 32'(vis && !etp));
            chk("fb_addr", 32'(fb_addr), 32'(last_addr));
            if (vis && !etp) exp_q.push_back(mem_f(15'(last_addr), mem_mode));
            if (t >= 1) begin
               tp = t - 1;
               hp = tp % 800;
               vp = (tp / 800) % 525;
               visp = (hp < 640) && (vp < 480);
               chk("hs", 32'(VGA_HS), 32'(!(hp >= 656 && hp <= 751)));
               chk("vs", 32'(VGA_VS), 32'(!(vp >= 490 && vp <= 491)));
               chk("blank_n", 32'(VGA_BLANK_N), 32'(visp));
               col = 0;
               if (visp) begin
                  if (etp) col = hp / 128;
                  else begin
                     chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                     if (exp_q.size() > 0) col = 32'(exp_q.pop_front());
                  end
               end
               chk("vga_r", 32'(VGA_R), col[2] ? 32'h3ff : 32'h0);
               chk("vga_g", 32'(VGA_G), col[1] ? 32'h3ff : 32'h0);
               chk("vga_b", 32'(VGA_B), col[0] ? 32'h3ff : 32'h0);
            end
         end
      end
   end

   // Whole-frame event counts on the narrow instance.
   bit win = 1'b0;
   int fs_cnt = 0, vs_cnt = 0, hs_cnt = 0, vb_cnt = 0, rd_cnt = 0, max_addr = 0;
   always @(negedge CLOCK_50) begin
      if (win) begin
         if (frame_start_s) fs_cnt++;
         if (!vs_s) vs_cnt++;
         if (!hs_s) hs_cnt++;
         if (vblank_s) vb_cnt++;
         if (fb_rd_en_s) begin
            rd_cnt++;
            if (int'(fb_addr_s) > max_addr) max_addr = int'(fb_addr_s);
         end
      end
   end

   task automatic release_reset();
      @(negedge CLOCK_50);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      // Power-on reset.
      #25;
      chk_reset_state();
      release_reset();
      repeat (4800) @(negedge CLOCK_50);

      // Asynchronous reset in the middle of a line, then constant-colour memory.
      repeat (701) @(negedge CLOCK_50);
      #3 reset_n = 1'b0;
      #1 chk_reset_state();
      repeat (3) @(negedge CLOCK_50);
      mem_mode = 1'b1;
      release_reset();
      repeat (3300) @(negedge CLOCK_50);

      // Colour bars (only honoured when the generator is built in).
      reset_n = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      test_pattern = 1'b1;
      mem_mode = 1'b0;
      release_reset();
      repeat (1700) @(negedge CLOCK_50);
      reset_n = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      test_pattern = 1'b0;

      // One full frame on both instances from a clean start.
      release_reset();
      win = 1'b1;
      repeat (16800) @(negedge CLOCK_50);
      win = 1'b0;
      chk("frame_start_count", 32'(fs_cnt), 32'd1);
      chk("vs_low_cycles", 32'(vs_cnt), 32'd64);
      chk("hs_low_cycles", 32'(hs_cnt), 32'd2100);
      chk("vblank_cycles", 32'(vb_cnt), 32'd1440);
      chk("rd_en_count", 32'(rd_cnt), 32'd3840);
      chk("last_visible_addr", 32'(max_addr), 32'd19041);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
